// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one req/ack memory port between instruction fetch (F)
//               and data access (M), with fetch cancel and a one-entry
//               instruction buffer for a held F stage.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              InstrReqF,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              HoldF,
  input  logic              FetchCancel,
  input  logic              DataReqM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              BusReq,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWData,
  input  logic              BusAck,
  input  logic [DATA_W-1:0] BusRData,
  output logic [DATA_W-1:0] InstrF,
  output logic              InstrValidF,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallFetch,
  output logic              StallMem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic                r_cancel_q;
  logic [DATA_W-1:0]   r_ibuf;
  logic                r_ibuf_valid;

  logic w_fetch_ack;
  logic w_data_ack;
  logic w_fetch_good;
  logic w_deliver;

  assign w_fetch_ack  = (r_state == ST_FETCH) & BusAck;
  assign w_data_ack   = (r_state == ST_DATA) & BusAck;
  assign w_fetch_good = ~r_cancel_q & ~FetchCancel;
  assign w_deliver    = w_fetch_ack & w_fetch_good & ~HoldF;

  assign BusReq      = r_bus_req;
  assign BusWe       = r_bus_we;
  assign BusAddr     = r_bus_addr;
  assign BusWData    = r_bus_wdata;
  assign ReadDataM   = BusRData;
  // A buffered instruction always takes precedence; no fetch runs while it is held.
  assign InstrF      = r_ibuf_valid ? r_ibuf : BusRData;
  assign InstrValidF = ~FetchCancel & (r_ibuf_valid | w_deliver);
  assign StallFetch  = InstrReqF & ~InstrValidF;
  assign StallMem    = DataReqM & ~w_data_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_cancel_q   <= 1'b0;
      r_ibuf       <= '0;
      r_ibuf_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cancel_q <= 1'b0;
          // M stage wins outright: a pending data access freezes the whole pipe.
          if (DataReqM) begin
            r_state     <= ST_DATA;
            r_bus_req   <= 1'b1;
            r_bus_addr  <= ALUResultM;
            r_bus_wdata <= WriteDataM;
            r_bus_we    <= MemWriteM;
          end else if (InstrReqF & ~r_ibuf_valid & ~FetchCancel) begin
            r_state    <= ST_FETCH;
            r_bus_req  <= 1'b1;
            r_bus_addr <= PCF;
            r_bus_we   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (FetchCancel) begin
            r_cancel_q <= 1'b1;
          end
          if (BusAck) begin
            r_state    <= ST_IDLE;
            r_bus_req  <= 1'b0;
            r_cancel_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (BusAck) begin
            r_state   <= ST_IDLE;
            r_bus_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
        end
      endcase

      if (w_fetch_ack & w_fetch_good & HoldF) begin
        r_ibuf       <= BusRData;
        r_ibuf_valid <= 1'b1;
      end else if (r_ibuf_valid & (~HoldF | FetchCancel)) begin
        r_ibuf_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a bus memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        InstrReqF, HoldF, FetchCancel, DataReqM, MemWriteM;
  logic [31:0] PCF, ALUResultM, WriteDataM;
  logic        BusReq, BusWe, BusAck;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [31:0] InstrF, ReadDataM;
  logic        InstrValidF, StallFetch, StallMem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .InstrReqF(InstrReqF), .PCF(PCF), .HoldF(HoldF), .FetchCancel(FetchCancel),
    .DataReqM(DataReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusAck(BusAck), .BusRData(BusRData),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .ReadDataM(ReadDataM),
    .StallFetch(StallFetch), .StallMem(StallMem)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } dexp_t;

  dexp_t       dq[$];
  logic [31:0] iq[$];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cfg_wait = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h100)  return 32'hE3A00001;
    if (a == 32'h500)  return 32'h12345678;
    if (a == 32'h2000) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual no event required event (t=%0t)", name, $time);
  endtask

  // Memory slave: configurable or random wait states, spurious acks while idle.
  initial begin
    int wait_left;
    wait_left = 0;
    BusAck    = 1'b0;
    BusRData  = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n && BusReq && BusAck && BusWe) bus_mem[BusAddr] = BusWData;
      @(posedge clk);
      #1;
      if (BusReq) begin
        if (wait_left == 0) begin
          BusAck   = 1'b1;
          BusRData = BusWe ? $urandom : bus_read(BusAddr);
        end else begin
          BusAck   = 1'b0;
          BusRData = $urandom;
          wait_left--;
        end
      end else begin
        wait_left = (cfg_wait < 0) ? int'($urandom_range(0, 3)) : cfg_wait;
        BusAck    = ($urandom_range(0, 5) == 0);
        BusRData  = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT hands over an instruction or data.
  logic        prev_req = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    dexp_t       de;
    logic [31:0] ie;
    if (reset_n) begin
      chk1("stall_fetch", StallFetch, InstrReqF & ~InstrValidF);
      if (FetchCancel) chk1("valid_on_cancel", InstrValidF, 1'b0);
      if (InstrValidF && !HoldF) begin
        if (iq.size() == 0) fail_now("instr_unexpected");
        else begin
          ie = iq.pop_front();
          chk("instr", InstrF, ie);
        end
      end
      if (DataReqM && !StallMem) begin
        if (dq.size() == 0) fail_now("data_unexpected");
        else begin
          de = dq.pop_front();
          chk("data_addr", BusAddr, de.addr);
          chk1("data_we", BusWe, de.we);
          if (de.we) chk("store_data", BusWData, de.wdata);
          else       chk("load_data", ReadDataM, de.rdata);
        end
      end
      if (BusReq && prev_req) begin
        chk("addr_stable", BusAddr, prev_addr);
        chk1("we_stable", BusWe, prev_we);
      end
      prev_req  = BusReq;
      prev_we   = BusWe;
      prev_addr = BusAddr;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic issue_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    dexp_t e;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.rdata = we ? 32'h0 : ref_read(addr);
    if (we) ref_mem[addr] = wdata;
    dq.push_back(e);
    DataReqM   = 1'b1;
    MemWriteM  = we;
    ALUResultM = addr;
    WriteDataM = wdata;
  endtask

  task automatic wait_instr(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      smp();
      if (InstrValidF && !HoldF) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_now(name);
  endtask

  task automatic wait_data(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      smp();
      if (DataReqM && !StallMem) ok = 1'b1;
      else tick();
    end
    if (!ok) fail_now(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        took_i, took_d, dpend;
    int          dage, iage;
    logic [31:0] pc;

    reset_n = 1'b0; HoldF = 1'b0; FetchCancel = 1'b0; MemWriteM = 1'b0;
    PCF = 32'h0; ALUResultM = 32'h0; WriteDataM = 32'h0;
    InstrReqF = 1'b1; DataReqM = 1'b1;
    #12;
    chk1("rst_stall_fetch", StallFetch, 1'b1);
    chk1("rst_stall_mem", StallMem, 1'b1);
    chk1("rst_busreq", BusReq, 1'b0);
    chk1("rst_valid", InstrValidF, 1'b0);
    chk("rst_addr", BusAddr, 32'h0);
    chk1("rst_we", BusWe, 1'b0);
    chk("rst_wdata", BusWData, 32'h0);
    InstrReqF = 1'b0; DataReqM = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Zero-wait fetch
    cfg_wait = 0;
    tick();
    InstrReqF = 1'b1; PCF = 32'h100; iq.push_back(ref_read(32'h100));
    smp(); chk1("s1_stallF_c1", StallFetch, 1'b1); chk1("s1_req_c1", BusReq, 1'b0);
    tick(); smp();
    chk1("s1_req_c2", BusReq, 1'b1); chk("s1_addr", BusAddr, 32'h100);
    chk1("s1_valid_c2", InstrValidF, 1'b1); chk("s1_instr", InstrF, 32'hE3A00001);
    chk1("s1_stallF_c2", StallFetch, 1'b0);
    tick(); InstrReqF = 1'b0;
    smp(); chk1("s1_valid_c3", InstrValidF, 1'b0); chk1("s1_req_c3", BusReq, 1'b0);

    // Load with three wait states
    cfg_wait = 3;
    tick();
    issue_data(1'b0, 32'h2000, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      smp();
      chk1("s2_stallM", StallMem, c < 5);
      if (c == 5) begin
        chk("s2_rdata", ReadDataM, 32'hDEADBEEF);
        chk1("s2_we", BusWe, 1'b0);
      end
      tick();
    end
    DataReqM = 1'b0;

    // Data request arrives while a fetch is in flight
    cfg_wait = 2;
    tick();
    InstrReqF = 1'b1; PCF = 32'h200; iq.push_back(ref_read(32'h200));
    smp(); tick();
    issue_data(1'b0, 32'h2004, 32'h0);
    smp(); chk1("s3_stallM", StallMem, 1'b1); chk("s3_faddr", BusAddr, 32'h200);
    tick(); smp(); tick(); smp();
    chk1("s3_fetch_done", InstrValidF, 1'b1);
    tick(); PCF = 32'h204; iq.push_back(ref_read(32'h204));
    smp(); chk1("s3_idle_gap", BusReq, 1'b0);
    tick(); smp();
    chk1("s3_data_req", BusReq, 1'b1); chk("s3_daddr", BusAddr, 32'h2004);
    wait_data("s3_data_timeout");
    tick(); DataReqM = 1'b0;
    wait_instr("s3_instr_timeout");
    tick(); InstrReqF = 1'b0;

    // Mispredict while a fetch is outstanding
    tick();
    InstrReqF = 1'b1; PCF = 32'h300; iq.push_back(ref_read(32'h300));
    smp(); tick(); smp(); tick();
    FetchCancel = 1'b1; PCF = 32'h400; iq.delete(); iq.push_back(ref_read(32'h400));
    smp(); chk1("s4_valid_cancel", InstrValidF, 1'b0);
    tick(); FetchCancel = 1'b0;
    smp(); chk1("s4_drop", InstrValidF, 1'b0); chk("s4_old_addr", BusAddr, 32'h300);
    tick(); smp(); chk1("s4_idle", BusReq, 1'b0);
    tick(); smp(); chk("s4_new_addr", BusAddr, 32'h400); chk1("s4_req", BusReq, 1'b1);
    wait_instr("s4_instr_timeout");
    tick(); InstrReqF = 1'b0;

    // Fetch return while F is held goes to the buffer
    cfg_wait = 0;
    tick();
    InstrReqF = 1'b1; PCF = 32'h500; HoldF = 1'b1; iq.push_back(ref_read(32'h500));
    smp(); tick(); smp(); chk1("s5_req_ack", BusReq, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk1("s5_no_req", BusReq, 1'b0);
      chk1("s5_held_valid", InstrValidF, 1'b1);
      chk("s5_held_instr", InstrF, 32'h12345678);
    end
    tick(); HoldF = 1'b0;
    smp(); chk1("s5_release", InstrValidF, 1'b1);
    tick(); PCF = 32'h504; iq.push_back(ref_read(32'h504));
    smp(); chk1("s5_idle", BusReq, 1'b0);
    tick(); smp(); chk1("s5_next_req", BusReq, 1'b1); chk("s5_next_addr", BusAddr, 32'h504);
    tick(); InstrReqF = 1'b0;

    // Asynchronous reset in the middle of a store
    cfg_wait = 3;
    tick();
    DataReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h2008; WriteDataM = 32'hCAFEF00D;
    smp(); tick();
    #2;
    chk1("s6_req_before", BusReq, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("s6_req_dropped", BusReq, 1'b0);
    chk1("s6_valid_dropped", InstrValidF, 1'b0);
    chk1("s6_stallM_rst", StallMem, 1'b1);
    DataReqM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    cfg_wait = 0;
    tick();
    issue_data(1'b0, 32'h2008, 32'h0);
    smp(); chk1("s6_post_c1", StallMem, 1'b1);
    tick(); smp(); chk1("s6_post_c2", StallMem, 1'b0);
    chk("s6_post_rdata", ReadDataM, init_word(32'h2008));
    tick(); DataReqM = 1'b0;

    // Randomised traffic against the scoreboard
    cfg_wait = -1;
    tick();
    pc = 32'h600; PCF = pc; InstrReqF = 1'b1;
    iq.delete(); iq.push_back(ref_read(pc));
    dpend = 1'b0; dage = 0; iage = 0;
    for (int n = 0; n < 3000; n++) begin
      smp();
      took_i = InstrValidF && !HoldF;
      took_d = DataReqM && !StallMem;
      if (dpend) dage++;
      iage++;
      tick();
      FetchCancel = 1'b0;
      if (took_d) begin
        DataReqM = 1'b0; dpend = 1'b0; dage = 0;
      end
      if (dage > 60) begin
        fail_now("data_timeout");
        DataReqM = 1'b0; dpend = 1'b0; dage = 0; dq.delete();
      end
      if (!dpend && $urandom_range(0, 3) == 0) begin
        issue_data($urandom_range(0, 1) == 1, 32'h2000 + 32'($urandom_range(0, 15) * 4), $urandom);
        dpend = 1'b1;
      end
      if (took_i) begin
        pc = (pc + 32'h4) & 32'hFFC;
        PCF = pc; iq.push_back(ref_read(pc)); iage = 0;
      end
      if ($urandom_range(0, 15) == 0) begin
        FetchCancel = 1'b1;
        pc = 32'h100 + 32'($urandom_range(0, 700) * 4);
        PCF = pc; iq.delete(); iq.push_back(ref_read(pc)); iage = 0;
      end
      if (iage > 80) begin
        fail_now("instr_timeout");
        iage = 0;
      end
      HoldF = ($urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
